// File: rtl/enc_block_scheduler.sv
// Block sequencer for the convolutional encoder: pops one meta byte, waits for a full
// block of input data, runs the encoder, then drains subblocks 0..2 as one byte stream.
module enc_block_scheduler #(
  parameter int SHORT_BYTES    = 132,
  parameter int LONG_BYTES     = 768,
  parameter int CNT_W          = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             meta_empty,
  input  logic [7:0]       meta_q,
  output logic             meta_rdreq,
  input  logic [CNT_W-1:0] data_usedw,
  output logic             enc_start,
  output logic             enc_size,
  input  logic             computation_done,
  output logic [2:0]       rdreq_subblock,
  input  logic [7:0]       q0,
  input  logic [7:0]       q1,
  input  logic [7:0]       q2,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sub,
  output logic             out_last,
  output logic             busy,
  output logic             err_timeout,
  output logic [15:0]      blocks_done
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Watchdog trips when its next value would reach TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] SHORT_N    = CNT_W'(SHORT_BYTES);
  localparam logic [CNT_W-1:0] LONG_N     = CNT_W'(LONG_BYTES);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_BYTES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_META_RD, S_META_CAP, S_WAIT_DATA, S_START,
    S_COMPUTE, S_RD_REQ, S_RD_CAP, S_HOLD
  } state_t;

  state_t           state_q;
  logic             size_q;
  logic [1:0]       sub_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic             meta_rdreq_q, enc_start_q, out_valid_q, out_last_q, err_q;
  logic [2:0]       rdreq_q;
  logic [7:0]       out_data_q;
  logic [1:0]       out_sub_q;
  logic [15:0]      blocks_q;

  logic [CNT_W-1:0] need_n;
  logic             last_byte;
  logic [1:0]       sub_nx;
  logic [7:0]       sub_byte;

  assign need_n    = size_q ? LONG_N : SHORT_N;
  assign last_byte = (cnt_q == (size_q ? LONG_LAST : SHORT_LAST));
  assign sub_nx    = sub_q + 2'd1;

  always_comb begin
    sub_byte = q2;
    case (sub_q)
      2'd0:    sub_byte = q0;
      2'd1:    sub_byte = q1;
      default: sub_byte = q2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      size_q       <= 1'b0;
      sub_q        <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      meta_rdreq_q <= 1'b0;
      enc_start_q  <= 1'b0;
      rdreq_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sub_q    <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
      blocks_q     <= '0;
    end else begin
      // strobes are high only for the single cycle spent in their state
      meta_rdreq_q <= 1'b0;
      enc_start_q  <= 1'b0;
      rdreq_q      <= '0;
      case (state_q)
        S_IDLE: if (!meta_empty) begin
          state_q      <= S_META_RD;
          meta_rdreq_q <= 1'b1;
        end
        S_META_RD:  state_q <= S_META_CAP;
        S_META_CAP: begin
          size_q  <= meta_q[0];
          state_q <= S_WAIT_DATA;
        end
        S_WAIT_DATA: if (data_usedw >= need_n) begin
          state_q     <= S_START;
          enc_start_q <= 1'b1;
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (computation_done) begin
            sub_q   <= '0;
            cnt_q   <= '0;
            rdreq_q <= 3'b001;
            state_q <= S_RD_REQ;
          end else if (wd_q == WD_LIMIT) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_RD_REQ: state_q <= S_RD_CAP;
        S_RD_CAP: begin
          out_data_q  <= sub_byte;
          out_sub_q   <= sub_q;
          out_valid_q <= 1'b1;
          out_last_q  <= (sub_q == 2'd2) && last_byte;
          state_q     <= S_HOLD;
        end
        S_HOLD: if (out_ready) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          if (last_byte) begin
            cnt_q <= '0;
            if (sub_q == 2'd2) begin
              blocks_q <= blocks_q + 16'd1;
              state_q  <= S_IDLE;
            end else begin
              sub_q   <= sub_nx;
              rdreq_q <= 3'b001 << sub_nx;
              state_q <= S_RD_REQ;
            end
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            rdreq_q <= 3'b001 << sub_q;
            state_q <= S_RD_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign meta_rdreq     = meta_rdreq_q;
  assign enc_start      = enc_start_q;
  assign enc_size       = size_q;
  assign rdreq_subblock = rdreq_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_sub        = out_sub_q;
  assign out_last       = out_last_q;
  assign busy           = (state_q != S_IDLE);
  assign err_timeout    = err_q;
  assign blocks_done    = blocks_q;

endmodule

// File: tb/tb_enc_block_scheduler.sv
// Bench for enc_block_scheduler: FIFO/encoder models around the DUT, stream scoreboard
// built from the block layout (3 subblocks x N bytes) and randomized handshakes.
module tb_enc_block_scheduler;
  localparam int SHORT = 132, LONG = 768, CW = 10, TMO = 4096;

  typedef struct packed {logic [7:0] d; logic [1:0] s; logic l;} item_t;

  logic          clk = 1'b0, reset = 1'b1;
  logic          meta_empty, meta_rdreq, enc_start, enc_size, computation_done;
  logic [7:0]    meta_q, q0, q1, q2, out_data;
  logic [CW-1:0] data_usedw = '0;
  logic [2:0]    rdreq_subblock;
  logic          out_valid, out_ready = 1'b1, out_last, busy, err_timeout;
  logic [1:0]    out_sub;
  logic [15:0]   blocks_done;

  always #5 clk = ~clk;

  enc_block_scheduler #(.SHORT_BYTES(SHORT), .LONG_BYTES(LONG), .CNT_W(CW),
                        .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .meta_empty(meta_empty), .meta_q(meta_q),
    .meta_rdreq(meta_rdreq), .data_usedw(data_usedw), .enc_start(enc_start),
    .enc_size(enc_size), .computation_done(computation_done),
    .rdreq_subblock(rdreq_subblock), .q0(q0), .q1(q1), .q2(q2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sub(out_sub), .out_last(out_last), .busy(busy),
    .err_timeout(err_timeout), .blocks_done(blocks_done));

  // meta FIFO model: read data appears the cycle after the pop
  logic [7:0] meta_mem [16];
  int         meta_wr = 0, meta_rd = 0;
  logic [7:0] meta_rdata = '0;
  assign meta_empty = (meta_wr == meta_rd);
  assign meta_q     = meta_rdata;
  always @(posedge clk)
    if (meta_rdreq) begin
      meta_rdata <= meta_mem[meta_rd % 16];
      meta_rd    <= meta_rd + 1;
    end

  // encoder model: three subblock buffers with sequential read pointers
  logic [7:0] mem [3][LONG];
  int         ptr [3];
  logic [7:0] qr [3];
  int         dcnt = 0;
  logic       done_lvl = 1'b0, withhold = 1'b0, done_kick = 1'b0;
  assign q0 = qr[0];
  assign q1 = qr[1];
  assign q2 = qr[2];
  assign computation_done = done_lvl | done_kick;
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (reset || enc_start) ptr[k] <= 0;
      else if (rdreq_subblock[k]) begin
        qr[k]  <= mem[k][ptr[k] % LONG];
        ptr[k] <= ptr[k] + 1;
      end
    if (reset) begin
      dcnt <= 0; done_lvl <= 1'b0;
    end else if (enc_start) begin
      done_lvl <= 1'b0;
      dcnt     <= withhold ? 0 : int'($urandom_range(1, 30));
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) done_lvl <= 1'b1;
    end
  end

  // monitor, sampled on the falling edge
  int    cyc = 0, n_meta = 0, n_start = 0, n_rdreq = 0, n_hs = 0, n_last = 0, viol = 0;
  int    start_cyc = 0, err_cyc = 0;
  logic  start_size = 1'b0, err_seen = 1'b0, prev_stall = 1'b0;
  item_t prev_item = '0;
  item_t cap_q[$], exp_q[$];
  int    meta_cyc_q[$], last_cyc_q[$];
  int    checks = 0, failures = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      err_seen <= 1'b0; prev_stall <= 1'b0;
    end else begin
      if (meta_rdreq) begin
        n_meta <= n_meta + 1;
        meta_cyc_q.push_back(cyc);
        if (meta_empty) viol <= viol + 1;
      end
      if (enc_start) begin
        n_start <= n_start + 1; start_cyc <= cyc; start_size <= enc_size;
      end
      if (rdreq_subblock != 3'b000) n_rdreq <= n_rdreq + 1;
      if ($countones(rdreq_subblock) > 1 || (out_last && !out_valid)) viol <= viol + 1;
      if (prev_stall && (!out_valid || prev_item !== item_t'({out_data, out_sub, out_last})))
        viol <= viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_item  <= {out_data, out_sub, out_last};
      if (out_valid && out_ready) begin
        cap_q.push_back({out_data, out_sub, out_last});
        n_hs <= n_hs + 1;
        if (out_last) begin
          n_last <= n_last + 1; last_cyc_q.push_back(cyc);
        end
      end
      if (err_timeout && !err_seen) begin
        err_seen <= 1'b1; err_cyc <= cyc;
      end
    end
  end

  // reference: subblock 0, 1, 2 in order, N bytes each, last flag on the final byte
  task automatic build_expect(input int n);
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < n; c++)
        exp_q.push_back({mem[s][c], 2'(s), (s == 2 && c == n - 1)});
  endtask

  function automatic int stream_diff();
    int e = (cap_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic reset_dut();
    reset = 1'b1; out_ready = 1'b1; withhold = 1'b0; done_kick = 1'b0;
    meta_wr = meta_rd;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cap_q.delete(); exp_q.delete(); meta_cyc_q.delete(); last_cyc_q.delete();
  endtask

  task automatic push_meta(input logic [7:0] b);
    meta_mem[meta_wr % 16] = b;
    meta_wr++;
  endtask

  task automatic wait_last(input int tgt, input int budget, output bit ok);
    int i = 0;
    while (n_last < tgt && i < budget) begin
      @(posedge clk); i++;
    end
    #1 ok = (n_last >= tgt);
  endtask

  task automatic test_reset();
    logic [35:0] v;
    reset_dut();
    v = {meta_rdreq, enc_start, enc_size, rdreq_subblock, out_data, out_valid, out_sub,
         out_last, busy, err_timeout, blocks_done};
    checks++;
    if (v !== 36'd0) begin $display("FAIL reset_outputs: got %h want 0", v); failures++; end
    repeat (5) @(posedge clk);
    #1 checks++;
    if (busy !== 1'b0) begin $display("FAIL reset_idle_busy: got %b want 0", busy); failures++; end
  endtask

  task automatic test_basic();
    int m0, s0, d; bit ok;
    reset_dut();
    data_usedw = CW'(SHORT);
    build_expect(SHORT);
    m0 = n_meta; s0 = n_start;
    push_meta(8'h00);
    wait_last(n_last + 1, 3000, ok);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (!ok) begin $display("FAIL basic_timeout: block never ended"); failures++; end
    checks++;
    if (n_meta - m0 !== 1) begin $display("FAIL basic_meta_pops: got %0d want 1", n_meta - m0); failures++; end
    checks++;
    if (n_start - s0 !== 1) begin $display("FAIL basic_starts: got %0d want 1", n_start - s0); failures++; end
    checks++;
    d = (meta_cyc_q.size() > 0) ? start_cyc - meta_cyc_q[0] : -1;
    if (d !== 3) begin $display("FAIL basic_start_latency: got %0d want 3", d); failures++; end
    checks++;
    if (start_size !== 1'b0) begin $display("FAIL basic_enc_size: got %b want 0", start_size); failures++; end
    checks++;
    d = stream_diff();
    if (d !== 0) begin
      $display("FAIL basic_stream: %0d diffs, got %0d bytes want %0d", d, cap_q.size(), exp_q.size());
      failures++;
    end
    checks++;
    if (blocks_done !== 16'd1) begin $display("FAIL basic_blocks_done: got %0d want 1", blocks_done); failures++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL basic_busy_end: got %b want 0", busy); failures++; end
  endtask

  task automatic test_wait_data();
    int s0, v, d; bit ok;
    reset_dut();
    data_usedw = '0;
    build_expect(LONG);
    s0 = n_start;
    push_meta(8'hA5);  // upper bits must be ignored, bit0 selects the long block
    v = 0;
    while (v < LONG - 1) begin
      data_usedw = CW'(v);
      @(posedge clk);
      #1 v += int'($urandom_range(1, 12));
    end
    data_usedw = CW'(LONG - 1);
    repeat (5) @(posedge clk);
    #1 checks++;
    if (n_start - s0 !== 0) begin $display("FAIL wait_early_start: got %0d starts want 0", n_start - s0); failures++; end
    checks++;
    if (busy !== 1'b1) begin $display("FAIL wait_busy: got %b want 1", busy); failures++; end
    data_usedw = CW'(LONG);
    wait_last(n_last + 1, 9000, ok);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (!ok) begin $display("FAIL wait_timeout: long block never ended"); failures++; end
    checks++;
    if (n_start - s0 !== 1) begin $display("FAIL wait_starts: got %0d want 1", n_start - s0); failures++; end
    checks++;
    if (start_size !== 1'b1) begin $display("FAIL wait_enc_size: got %b want 1", start_size); failures++; end
    checks++;
    d = stream_diff();
    if (d !== 0) begin
      $display("FAIL wait_stream: %0d diffs, got %0d bytes want %0d", d, cap_q.size(), exp_q.size());
      failures++;
    end
  endtask

  task automatic test_backpressure();
    int r0, h0, v0, tgt, d; bit stalled = 1'b0;
    reset_dut();
    data_usedw = CW'(SHORT);
    build_expect(SHORT);
    r0 = n_rdreq; h0 = n_hs; v0 = viol; tgt = n_last + 1;
    push_meta(8'h00);
    for (int i = 0; i < 8000 && n_last < tgt; i++) begin
      @(posedge clk);
      #1;
      if (!stalled && cap_q.size() >= SHORT + 60) begin
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 stalled = 1'b1;
      end else out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (n_last < tgt) begin $display("FAIL bp_timeout: block never ended"); failures++; end
    checks++;
    d = stream_diff();
    if (d !== 0) begin
      $display("FAIL bp_stream: %0d diffs, got %0d bytes want %0d", d, cap_q.size(), exp_q.size());
      failures++;
    end
    checks++;
    if (n_rdreq - r0 !== 3 * SHORT) begin $display("FAIL bp_rdreq_count: got %0d want %0d", n_rdreq - r0, 3 * SHORT); failures++; end
    checks++;
    if (n_hs - h0 !== 3 * SHORT) begin $display("FAIL bp_handshakes: got %0d want %0d", n_hs - h0, 3 * SHORT); failures++; end
    checks++;
    if (viol - v0 !== 0) begin $display("FAIL bp_protocol: got %0d violations want 0", viol - v0); failures++; end
  endtask

  task automatic test_timeout();
    int r0, i; bit ok;
    reset_dut();
    withhold = 1'b1;
    data_usedw = CW'(SHORT);
    r0 = n_rdreq;
    push_meta(8'h00);
    i = 0;
    while (!err_seen && i < TMO + 200) begin
      @(posedge clk); i++;
    end
    ok = err_seen;
    repeat (2) @(posedge clk);
    #1 checks++;
    if (!ok) begin $display("FAIL tmo_never: err_timeout not raised"); failures++; end
    checks++;
    if (err_cyc - start_cyc !== TMO) begin $display("FAIL tmo_latency: got %0d want %0d", err_cyc - start_cyc, TMO); failures++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL tmo_busy: got %b want 0", busy); failures++; end
    checks++;
    if (blocks_done !== 16'd0) begin $display("FAIL tmo_blocks: got %0d want 0", blocks_done); failures++; end
    done_kick = 1'b1;  // a late done while idle must not start a drain
    @(posedge clk);
    #1 done_kick = 1'b0;
    repeat (6) @(posedge clk);
    #1 checks++;
    if (n_rdreq - r0 !== 0) begin $display("FAIL tmo_rdreq: got %0d want 0", n_rdreq - r0); failures++; end
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL tmo_sticky: got err=%b busy=%b want err=1 busy=0", err_timeout, busy); failures++;
    end
    withhold = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [35:0] v; int i, m0, d; bit ok;
    reset_dut();
    data_usedw = CW'(SHORT);
    push_meta(8'h00);
    i = 0;
    while (cap_q.size() < SHORT + 10 && i < 3000) begin
      @(posedge clk); i++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    v = {meta_rdreq, enc_start, enc_size, rdreq_subblock, out_data, out_valid, out_sub,
         out_last, busy, err_timeout, blocks_done};
    checks++;
    if (v !== 36'd0) begin $display("FAIL mid_reset_outputs: got %h want 0", v); failures++; end
    cap_q.delete(); exp_q.delete();
    build_expect(SHORT);
    m0 = n_meta;
    push_meta(8'h00);
    wait_last(n_last + 1, 3000, ok);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (!ok) begin $display("FAIL mid_timeout: block after reset never ended"); failures++; end
    checks++;
    d = stream_diff();
    if (d !== 0) begin
      $display("FAIL mid_stream: %0d diffs, got %0d bytes want %0d", d, cap_q.size(), exp_q.size());
      failures++;
    end
    checks++;
    if (n_meta - m0 !== 1) begin $display("FAIL mid_meta_pops: got %0d want 1", n_meta - m0); failures++; end
    checks++;
    if (blocks_done !== 16'd1) begin $display("FAIL mid_blocks_done: got %0d want 1", blocks_done); failures++; end
  endtask

  task automatic test_back_to_back();
    int d, gap; bit ok;
    reset_dut();
    data_usedw = CW'(LONG);
    build_expect(SHORT);
    build_expect(LONG);
    push_meta(8'h00);
    push_meta(8'h01);
    wait_last(n_last + 2, 12000, ok);
    repeat (3) @(posedge clk);
    #1 checks++;
    if (!ok) begin $display("FAIL b2b_timeout: both blocks did not end"); failures++; end
    checks++;
    d = stream_diff();
    if (d !== 0) begin
      $display("FAIL b2b_stream: %0d diffs, got %0d bytes want %0d", d, cap_q.size(), exp_q.size());
      failures++;
    end
    checks++;
    gap = (meta_cyc_q.size() == 2 && last_cyc_q.size() > 0) ? meta_cyc_q[1] - last_cyc_q[0] : -1;
    if (gap !== 2) begin $display("FAIL b2b_second_pop: got gap %0d want 2", gap); failures++; end
    checks++;
    if (blocks_done !== 16'd2) begin $display("FAIL b2b_blocks_done: got %0d want 2", blocks_done); failures++; end
    checks++;
    if (viol !== 0) begin $display("FAIL protocol_total: got %0d violations want 0", viol); failures++; end
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < LONG; c++) mem[s][c] = 8'($urandom);
    test_reset();
    test_basic();
    test_wait_data();
    test_backpressure();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
